prime_sweep_ctrl: RTL

Sequencer that drives one `prime` checker across a user-selected range [lo_i, hi_i]. It issues one value at a time and holds the value stable while the checker runs. It collects the prime/non-prime results into a bitmap and a prime count. It sits between the user/button front end and the `prime` datapath, and screens out values the checker cannot handle (0, 1).

---
 rtl/prime_pkg.sv | 20 ++
 rtl/prime_sweep_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/prime_pkg.sv
// Shared definitions for the prime checker and the sweep controller that drives it.
package prime_pkg;

    // Data width of the prime checker and of every value the sweep issues.
    localparam int PRIME_WIDTH = 4;

    // Smallest value the checker can classify; anything below is non-prime.
    localparam int PRIME_MIN = 2;

    // Sweep controller states, one-hot encoded.
    typedef enum logic [5:0] {
        S_IDLE      = 6'b000001,
        S_ISSUE     = 6'b000010,
        S_WAIT_BUSY = 6'b000100,
        S_WAIT_DONE = 6'b001000,
        S_NEXT      = 6'b010000,
        S_DONE      = 6'b100000
    } state_t;

endpackage

// File: rtl/prime_sweep_ctrl.sv
// Sweep sequencer: walks cur from lo to hi, hands each value >= PRIME_MIN to
// the prime checker and gathers results into bitmap_o / count_o.
// Optional per-check watchdog: define PRIME_SWEEP_TIMEOUT_EN.
module prime_sweep_ctrl
    import prime_pkg::*;
#(
    parameter int WIDTH          = PRIME_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      lo_i,
    input  logic [WIDTH-1:0]      hi_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [WIDTH:0]        count_o,
    output logic [(2**WIDTH)-1:0] bitmap_o,
    output logic                  err_o,
    output logic                  chk_en_o,
    output logic [WIDTH-1:0]      chk_data_o,
    input  logic                  chk_valid_i,
    input  logic                  chk_prime_i
);

    localparam int              MAP_W   = 2**WIDTH;
    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(PRIME_MIN);
    localparam logic [WIDTH:0]   CNT_ONE = (WIDTH+1)'(1);

    // Reject configurations the watchdog and checker interface cannot support.
    if (WIDTH < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("prime_sweep_ctrl: WIDTH and TIMEOUT_CYCLES must both be >= 2");
    end

    state_t             state_r;
    logic [WIDTH-1:0]   cur_r;
    logic [WIDTH-1:0]   hi_r;
    logic               busy_r;
    logic               done_r;
    logic               en_r;
    logic [WIDTH:0]     count_r;
    logic [MAP_W-1:0]   bitmap_r;
    logic [WIDTH-1:0]   cur_inc_s;
    logic               wait_abort_s;

    // cur only advances when cur != hi, so this increment never wraps.
    assign cur_inc_s = cur_r + WIDTH'(1);

`ifdef PRIME_SWEEP_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_r;
    logic             err_r;

    // Abort the current check once it has spent TIMEOUT_CYCLES waiting.
    assign wait_abort_s = ((state_r == S_WAIT_BUSY) || (state_r == S_WAIT_DONE))
                          && (tmo_r == TMO_LAST);

    // Per-check watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_r <= '0;
            err_r <= 1'b0;
        end else begin
            if (state_r == S_ISSUE) begin
                tmo_r <= '0;
            end else if ((state_r == S_WAIT_BUSY) || (state_r == S_WAIT_DONE)) begin
                tmo_r <= tmo_r + TMO_W'(1);
            end
            if ((state_r == S_IDLE) && start_i) begin
                err_r <= 1'b0;
            end else if (wait_abort_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign err_o = err_r;
`else
    // Without the watchdog the controller waits on the checker indefinitely.
    assign wait_abort_s = 1'b0;
    assign err_o        = 1'b0;
`endif

    // Sweep FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            cur_r    <= '0;
            hi_r     <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            en_r     <= 1'b0;
            count_r  <= '0;
            bitmap_r <= '0;
        end else begin
            en_r   <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        hi_r     <= hi_i;
                        cur_r    <= lo_i;
                        bitmap_r <= '0;
                        count_r  <= '0;
                        busy_r   <= 1'b1;
                        if (lo_i > hi_i) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= S_ISSUE;
                            en_r    <= (lo_i >= MIN_VAL);
                        end
                    end
                end
                S_ISSUE: begin
                    // en_r is high exactly when cur can be handed to the checker.
                    state_r <= en_r ? S_WAIT_BUSY : S_NEXT;
                end
                S_WAIT_BUSY: begin
                    if (wait_abort_s) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                    end else if (!chk_valid_i) begin
                        state_r <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (wait_abort_s) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                    end else if (chk_valid_i) begin
                        if (chk_prime_i) begin
                            bitmap_r[cur_r] <= 1'b1;
                            count_r         <= count_r + CNT_ONE;
                        end
                        state_r <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (cur_r == hi_r) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        cur_r   <= cur_inc_s;
                        en_r    <= (cur_inc_s >= MIN_VAL);
                        state_r <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign count_o    = count_r;
    assign bitmap_o   = bitmap_r;
    assign chk_en_o   = en_r;
    assign chk_data_o = cur_r;

endmodule
